// File: rtl/core101_sequencer.sv
// rtl/core101_sequencer.sv - multi-cycle fetch/exec sequencer with halt, redirect, fault and retire count
module core101_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              CNT_W        = 32
) (
    input  logic             CLOCK,
    input  logic             RESET,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic             exec_valid,
    output logic [31:0]      exec_instr,
    output logic [XLEN-1:0]  exec_pc,
    input  logic             exec_done,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             halt,
    output logic             halted,
    output logic             fault,
    output logic [XLEN-1:0]  fault_addr,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [31:0]       ir;
    logic [CNT_W-1:0]  retired_q;
    logic              fault_q;
    logic [XLEN-1:0]   fault_addr_q;
    // Set on every edge that sees RESET high; keeps the fetch request quiet
    // for the whole reset window without a combinational RESET->output path.
    logic              in_reset;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state        <= S_FETCH;
            pc           <= RESET_VECTOR;
            ir           <= 32'h0;
            retired_q    <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            in_reset     <= 1'b1;
        end else begin
            in_reset <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (!in_reset) begin
                        if (imem_req_ready) begin
                            state <= S_WAIT;
                        end else if (halt) begin
                            state <= S_HALTED;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        ir    <= imem_rsp_data;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        retired_q <= retired_q + CNT_W'(1);
                        // A misaligned target still retires the instruction but freezes the PC.
                        if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                            fault_q      <= 1'b1;
                            fault_addr_q <= redirect_target;
                            state        <= S_FAULT;
                        end else begin
                            pc    <= redirect_valid ? redirect_target : pc + XLEN'(4);
                            state <= halt ? S_HALTED : S_FETCH;
                        end
                    end
                end
                S_HALTED: begin
                    if (!halt) begin
                        state <= S_FETCH;
                    end
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_req_valid = (state == S_FETCH) && !in_reset;
    assign imem_addr      = pc;
    assign exec_valid     = (state == S_EXEC);
    assign exec_instr     = ir;
    assign exec_pc        = pc;
    assign halted         = (state == S_HALTED);
    assign fault          = fault_q;
    assign fault_addr     = fault_addr_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_core101_sequencer.sv
// tb/tb_core101_sequencer.sv - randomized self-checking bench for core101_sequencer
module tb_core101_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rsp_data;
    logic        exec_valid, exec_done, redirect_valid, halt, halted, fault;
    logic [31:0] exec_instr, exec_pc, redirect_target, fault_addr, retired;

    logic        s_rst, s_req_valid, s_req_ready, s_rsp_valid, s_exec_valid, s_done;
    logic        s_redir, s_halt, s_halted, s_fault;
    logic [7:0]  s_addr, s_exec_pc, s_tgt, s_fault_addr;
    logic [31:0] s_rsp_data, s_exec_instr;
    logic [3:0]  s_retired;

    core101_sequencer dut (
        .CLOCK(clk), .RESET(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .exec_valid(exec_valid), .exec_instr(exec_instr), .exec_pc(exec_pc), .exec_done(exec_done),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target), .halt(halt),
        .halted(halted), .fault(fault), .fault_addr(fault_addr), .retired(retired)
    );

    core101_sequencer #(.XLEN(8), .RESET_VECTOR(8'hFC), .CNT_W(4)) dut_s (
        .CLOCK(clk), .RESET(s_rst),
        .imem_req_valid(s_req_valid), .imem_req_ready(s_req_ready), .imem_addr(s_addr),
        .imem_rsp_valid(s_rsp_valid), .imem_rsp_data(s_rsp_data),
        .exec_valid(s_exec_valid), .exec_instr(s_exec_instr), .exec_pc(s_exec_pc), .exec_done(s_done),
        .redirect_valid(s_redir), .redirect_target(s_tgt), .halt(s_halt),
        .halted(s_halted), .fault(s_fault), .fault_addr(s_fault_addr), .retired(s_retired)
    );

    int          ncmp = 0;
    int          nfail = 0;
    logic [31:0] m_pc;
    int unsigned m_ret;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; exec_done = 1'b0;
        redirect_valid = 1'b0; halt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_exec_pc", exec_pc, 0);
        chk("rst_exec_valid", exec_valid, 0);
        chk("rst_exec_instr", exec_instr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        chk("rst_fault_addr", fault_addr, 0);
        chk("rst_retired", retired, 0);
        rst = 1'b0;
        @(negedge clk);
        m_pc  = 32'h0;
        m_ret = 0;
    endtask

    // Called at a negedge where the sequencer is expected to be requesting m_pc.
    task automatic do_instr(input int rdly, input int qdly, input int ddly, input logic [31:0] word,
                            input bit redir, input logic [31:0] tgt, input bit hlt_exec, input bit hlt_fetch);
        bit mis;
        chk("fetch_valid", imem_req_valid, 1);
        chk("fetch_addr", imem_addr, m_pc);
        imem_req_ready = 1'b0;
        for (int i = 0; i < rdly; i++) begin
            imem_rsp_valid = ($urandom_range(0, 1) == 1);
            imem_rsp_data  = $urandom;
            @(negedge clk);
            chk("hold_valid", imem_req_valid, 1);
            chk("hold_addr", imem_addr, m_pc);
        end
        imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; halt = hlt_fetch;
        @(negedge clk);
        imem_req_ready = 1'b0; halt = 1'b0;
        for (int i = 0; i < qdly; i++) begin
            exec_done       = ($urandom_range(0, 1) == 1);
            redirect_valid  = ($urandom_range(0, 1) == 1);
            redirect_target = $urandom;
            @(negedge clk);
            chk("wait_req", imem_req_valid, 0);
            chk("wait_exec", exec_valid, 0);
        end
        exec_done = 1'b0; redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = word;
        @(negedge clk);
        imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
        chk("exec_valid", exec_valid, 1);
        chk("exec_instr", exec_instr, word);
        chk("exec_pc", exec_pc, m_pc);
        for (int i = 0; i < ddly; i++) begin
            redirect_valid  = ($urandom_range(0, 1) == 1);
            redirect_target = $urandom | 32'h1;
            imem_rsp_valid  = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            chk("exec_hold", exec_valid, 1);
            chk("exec_hold_ret", retired, 64'(m_ret));
        end
        imem_rsp_valid = 1'b0;
        redirect_valid = redir; redirect_target = tgt; exec_done = 1'b1; halt = hlt_exec;
        @(negedge clk);
        exec_done = 1'b0; redirect_valid = 1'b0;
        mis   = redir && (tgt % 4 != 0);
        m_ret = m_ret + 1;
        if (!mis) m_pc = redir ? tgt : m_pc + 32'd4;
        chk("retired", retired, 64'(m_ret));
        chk("exec_cleared", exec_valid, 0);
        if (mis) begin
            chk("fault_set", fault, 1);
            chk("fault_addr", fault_addr, tgt);
            for (int i = 0; i < 5; i++) begin
                halt           = ($urandom_range(0, 1) == 1);
                imem_req_ready = 1'b1;
                imem_rsp_valid = 1'b1;
                exec_done      = 1'b1;
                @(negedge clk);
                chk("fault_noreq", imem_req_valid, 0);
                chk("fault_noexec", exec_valid, 0);
                chk("fault_sticky", fault, 1);
                chk("fault_pc", imem_addr, m_pc);
                chk("fault_ret", retired, 64'(m_ret));
            end
            imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; exec_done = 1'b0; halt = 1'b0;
        end else begin
            chk("no_fault", fault, 0);
            if (hlt_exec) begin
                for (int i = 0; i < 3; i++) begin
                    chk("halted", halted, 1);
                    chk("halted_noreq", imem_req_valid, 0);
                    @(negedge clk);
                end
                halt = 1'b0;
                @(negedge clk);
            end
            chk("not_halted", halted, 0);
        end
    endtask

    initial begin
        int nf;
        logic [7:0] spc;
        s_rst = 1'b1; s_req_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_data = 32'h0;
        s_done = 1'b0; s_redir = 1'b0; s_tgt = 8'h0; s_halt = 1'b0;
        imem_rsp_data = 32'h0; redirect_target = 32'h0;

        do_reset();
        for (int k = 0; k < 4; k++) do_instr(0, 0, 0, 32'h1000 + k, 0, 0, 0, 0);
        chk("four_retired", retired, 4);
        do_instr(5, 3, 0, 32'h00500093, 0, 0, 0, 0);
        do_instr(0, 0, 1, 32'h12345678, 0, 0, 1, 0);
        chk("resume_addr", imem_addr, 24);
        do_instr(0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 1);

        // Halt while a fetch cannot be accepted.
        halt = 1'b1; imem_req_ready = 1'b0;
        @(negedge clk);
        chk("fetch_halt", halted, 1);
        chk("fetch_halt_noreq", imem_req_valid, 0);
        halt = 1'b0;
        @(negedge clk);
        chk("fetch_resume", imem_addr, m_pc);

        do_instr(1, 1, 1, 32'hCAFE0001, 1, 32'h00000102, 0, 0);
        do_reset();
        chk("post_fault_addr", imem_addr, 0);
        do_instr(0, 0, 0, 32'h11, 0, 0, 0, 0);
        do_instr(0, 0, 0, 32'h22, 0, 0, 0, 0);
        chk("redir_pc8", exec_pc, 8);
        do_instr(0, 0, 0, 32'h33, 1, 32'h100, 0, 0);
        chk("redir_addr", imem_addr, 32'h100);

        // Reset while a response is outstanding; the late response must be ignored.
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        do_reset();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBADBAD00;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk("late_rsp_exec", exec_valid, 0);
        chk("late_rsp_req", imem_req_valid, 1);

        for (int k = 0; k < 40; k++) begin
            do_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom,
                     ($urandom_range(0, 2) == 0), $urandom & 32'h0000FFFC,
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
        end

        // Narrow instance: 8-bit PC wrap from 0xFC and 4-bit retire counter wrap.
        @(negedge clk);
        chk("small_rst_addr", s_addr, 8'hFC);
        chk("small_rst_valid", s_req_valid, 0);
        s_rst = 1'b0; s_req_ready = 1'b1; s_rsp_valid = 1'b1; s_done = 1'b1;
        nf  = 0;
        spc = 8'hFC;
        for (int c = 0; c < 120 && nf < 17; c++) begin
            @(negedge clk);
            if (s_req_valid) begin
                chk("small_addr", s_addr, spc);
                if (nf == 1) chk("small_second", s_addr, 8'h00);
                spc = spc + 8'd4;
                nf++;
            end
        end
        chk("small_fetches", nf, 17);
        @(negedge clk);
        s_req_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("small_retired", s_retired, nf % 16);
        chk("small_no_fault", s_fault, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/core101_sequencer.md
# core101_sequencer

Parametrised multi-cycle instruction sequencer for Core101, the generalised successor of the core top-level control. It owns the program counter and instruction register, fetches through a valid/ready instruction-memory port, and presents one instruction at a time to the datapath/control pair. It adds halt, branch redirect, misalignment fault detection and a retired-instruction counter.

## Interface
- XLEN, 32: address/PC width in bits (≥ 8).
- RESET_VECTOR, 0: PC value after reset; must be 4-byte aligned.
- CNT_W, 32: retired-instruction counter width.

- CLOCK  in  1  single system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  XLEN  fetch address, equal to PC.
- imem_rsp_valid  in  1  fetch data valid.
- imem_rsp_data  in  32  fetched instruction.
- exec_valid  out  1  instruction presented to datapath.
- exec_instr  out  32  instruction register.
- exec_pc  out  XLEN  PC of presented instruction.
- exec_done  in  1  datapath finished current instruction.
- redirect_valid  in  1  taken branch/jump; sampled only with exec_done.
- redirect_target  in  XLEN  next PC when redirect_valid.
- halt  in  1  request to stop after current instruction.
- halted  out  1  sequencer in HALTED.
- fault  out  1  sticky misaligned-target fault.
- fault_addr  out  XLEN  offending redirect target.
- retired  out  CNT_W  instructions retired since reset.

## Operation
- States: FETCH, WAIT, EXEC, HALTED, FAULT. Reset state FETCH.
- Reset: PC=RESET_VECTOR, IR=0, retired=0, fault=0, fault_addr=0. While RESET high, all outputs 0 except imem_addr=exec_pc=RESET_VECTOR.
- FETCH: imem_req_valid=1, imem_addr=PC. halt high and imem_req_ready low → HALTED (no request issued). imem_req_ready high → WAIT (request accepted even if halt high).
- WAIT: imem_req_valid=0. imem_rsp_valid high → IR=imem_rsp_data, → EXEC. Otherwise stay (no timeout).
- EXEC: exec_valid=1, exec_instr=IR, exec_pc=PC. On exec_done: retired+1 (wraps modulo 2^CNT_W); next PC = redirect_target if redirect_valid else PC+4 (wraps modulo 2^XLEN). Then → HALTED if halt high, else → FETCH.
- Misaligned redirect (redirect_valid & exec_done & target[1:0]≠0): instruction still retires; PC unchanged; fault=1, fault_addr=target; → FAULT.
- HALTED: halted=1, no requests. halt low → FETCH at current PC.
- FAULT: fault=1, no requests, no exec_valid; left only by RESET. halt ignored.
- imem_rsp_valid outside WAIT, exec_done outside EXEC, redirect_valid without exec_done: ignored.
- RESET mid-transaction: aborts immediately; a response for an outstanding request arriving after reset release is ignored unless in WAIT.

## Timing
- All outputs Moore-decoded from registered state, PC, IR, counters; no combinational input→output paths.
- Minimum 3 cycles/instruction: FETCH (ready=1) → WAIT (rsp=1) → EXEC (done=1).
- imem_req_valid held with stable imem_addr until imem_req_ready.
- retired, PC, fault update on the edge that leaves EXEC; visible next cycle.
- First request: cycle after RESET deasserts, addr=RESET_VECTOR.

## Test plan
- Reset, ready/rsp always 1, done on first EXEC cycle, 4 instructions → addresses 0,4,8,12; one request every 3 cycles; retired=4.
- imem_req_ready low 5 cycles, rsp delayed 3 cycles → addr stable while pending; exec_instr equals delivered word (e.g. 0x00500093).
- Redirect at PC=8 to 0x100 with done → next imem_addr=0x100; retired increments; no fault.
- Redirect to 0x102 → fault=1, fault_addr=0x102, imem_req_valid stays 0 until RESET; after RESET, fetch from RESET_VECTOR, fault=0.
- halt asserted during EXEC → HALTED after done, halted=1, no requests; halt released → fetch resumes at PC+4.
- CNT_W=4, 17 retirements → retired=1; XLEN=8, RESET_VECTOR=0xFC → second fetch at 0x00.
